// File: rtl/wormhole_pkg.sv
// Shared definitions for the wormhole mesh node arbiters.
// Contents:
//   FLIT_HEAD/BODY/TAIL/SINGLE - flit type encodings carried alongside every flit
//   arb_state_e                - output-arbiter state (idle or locked to one packet)
//   is_pkt_start()             - true for flit types that may open a packet
package wormhole_pkg;

  localparam int unsigned FLIT_TYPE_W = 2;

  localparam logic [FLIT_TYPE_W-1:0] FLIT_HEAD   = 2'b10;
  localparam logic [FLIT_TYPE_W-1:0] FLIT_BODY   = 2'b00;
  localparam logic [FLIT_TYPE_W-1:0] FLIT_TAIL   = 2'b01;
  localparam logic [FLIT_TYPE_W-1:0] FLIT_SINGLE = 2'b11;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // HEAD and SINGLE both carry routing info, i.e. the MSB of the type field.
  function automatic logic is_pkt_start(input logic [FLIT_TYPE_W-1:0] flit);
    return (flit == FLIT_HEAD) || (flit == FLIT_SINGLE);
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker.
// Returns the first set bit of `eligible` searching upward from rr_ptr+1,
// wrapping modulo IN_N, so the most recently served index gets lowest priority.
// Ports:
//   eligible - one bit per candidate
//   rr_ptr   - index of the last winner
//   winner   - selected index (0 when nothing is eligible)
//   any_vld  - at least one candidate is eligible
module rr_priority_picker #(
  parameter int unsigned IN_N  = 5,
  parameter int unsigned IDX_W = (IN_N > 1) ? $clog2(IN_N) : 1
) (
  input  logic [IN_N-1:0]  eligible,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [IDX_W-1:0] winner,
  output logic             any_vld
);

  always_comb begin
    int unsigned idx;
    idx     = 0;
    winner  = '0;
    any_vld = 1'b0;
    // Offset IN_N wraps back to rr_ptr itself, which therefore has lowest priority.
    for (int unsigned k = 1; k <= IN_N; k++) begin
      idx = (32'(rr_ptr) + k) % IN_N;
      if (!any_vld && eligible[idx]) begin
        any_vld = 1'b1;
        winner  = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/wormhole_output_arbiter.sv
// Per-output-port packet arbiter for the 2D-mesh wormhole node.
// Grants the output to one input at packet start (round-robin), then holds the
// grant until that packet's TAIL flit has been transferred downstream.
// Ports:
//   clk_i, rst_i - clock, asynchronous active-high reset
//   req_i        - per-input flit-valid for this output
//   flit_id_i    - per-input flit type, input i at [i*FLIT_ID_W +: FLIT_ID_W]
//   out_rdy_i    - downstream FIFO can accept a flit
//   gnt_o        - one-hot, input i's flit is consumed this cycle
//   sel_o        - crossbar select (input index)
//   out_vld_o    - flit written downstream this cycle
//   locked_o     - a packet currently owns the output
//   err_o        - sticky protocol-error flag
//   stall_o      - owner has not transferred for STALL_MAX cycles
//   pkt_cnt_o    - completed packet count, wraps
module wormhole_output_arbiter
  import wormhole_pkg::*;
#(
  parameter int unsigned IN_N      = 5,
  parameter int unsigned FLIT_ID_W = 2,
  parameter int unsigned STALL_MAX = 16,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [IN_N-1:0]           req_i,
  input  logic [IN_N*FLIT_ID_W-1:0] flit_id_i,
  input  logic                      out_rdy_i,
  output logic [IN_N-1:0]           gnt_o,
  output logic [$clog2(IN_N)-1:0]   sel_o,
  output logic                      out_vld_o,
  output logic                      locked_o,
  output logic                      err_o,
  output logic                      stall_o,
  output logic [CNT_W-1:0]          pkt_cnt_o
);

  localparam int unsigned IDX_W   = (IN_N > 1) ? $clog2(IN_N) : 1;
  localparam int unsigned STALL_W = $clog2(STALL_MAX + 1);

  arb_state_e          state_q;
  logic [IDX_W-1:0]    rr_ptr_q;
  logic [IDX_W-1:0]    owner_q;
  logic [STALL_W-1:0]  stall_cnt_q;
  logic                err_q;
  logic [CNT_W-1:0]    pkt_cnt_q;

  logic [FLIT_ID_W-1:0] flit [IN_N];
  logic [IN_N-1:0]      eligible;
  logic [IN_N-1:0]      bad_idle;
  logic [IDX_W-1:0]     winner;
  logic                 any_vld;
  logic [FLIT_ID_W-1:0] owner_flit;
  logic [FLIT_ID_W-1:0] winner_flit;
  logic                 owner_req;

  // Split the flat flit-type bus and classify each requester.
  always_comb begin
    for (int unsigned i = 0; i < IN_N; i++) begin
      flit[i]     = flit_id_i[i*FLIT_ID_W +: FLIT_ID_W];
      eligible[i] = req_i[i] && is_pkt_start(FLIT_TYPE_W'(flit[i]));
      bad_idle[i] = req_i[i] && !is_pkt_start(FLIT_TYPE_W'(flit[i]));
    end
  end

  assign owner_flit  = flit[owner_q];
  assign winner_flit = flit[winner];
  assign owner_req   = req_i[owner_q];

  rr_priority_picker #(
    .IN_N  (IN_N),
    .IDX_W (IDX_W)
  ) u_picker (
    .eligible (eligible),
    .rr_ptr   (rr_ptr_q),
    .winner   (winner),
    .any_vld  (any_vld)
  );

  // Zero-latency grant path. Gated by rst_i so a held reset silences the
  // crossbar even though the requests themselves are still present.
  always_comb begin
    gnt_o     = '0;
    sel_o     = '0;
    out_vld_o = 1'b0;
    if (!rst_i) begin
      unique case (state_q)
        ARB_IDLE: begin
          if (any_vld && out_rdy_i) begin
            gnt_o[winner] = 1'b1;
            sel_o         = winner;
            out_vld_o     = 1'b1;
          end
        end
        ARB_LOCKED: begin
          sel_o = owner_q;
          if (owner_req && out_rdy_i) begin
            gnt_o[owner_q] = 1'b1;
            out_vld_o      = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ARB_IDLE;
      rr_ptr_q    <= IDX_W'(IN_N - 1);
      owner_q     <= '0;
      stall_cnt_q <= '0;
      err_q       <= 1'b0;
      pkt_cnt_q   <= '0;
    end else begin
      unique case (state_q)
        ARB_IDLE: begin
          stall_cnt_q <= '0;
          // A BODY/TAIL without an open packet means an upstream lost a HEAD.
          if (|bad_idle) begin
            err_q <= 1'b1;
          end
          if (out_vld_o) begin
            if (winner_flit == FLIT_ID_W'(FLIT_HEAD)) begin
              state_q <= ARB_LOCKED;
              owner_q <= winner;
            end else begin
              rr_ptr_q  <= winner;
              pkt_cnt_q <= pkt_cnt_q + CNT_W'(1);
            end
          end
        end
        ARB_LOCKED: begin
          // A new packet start from the owner is flagged but still forwarded;
          // only a TAIL releases the lock.
          if (owner_req && is_pkt_start(FLIT_TYPE_W'(owner_flit))) begin
            err_q <= 1'b1;
          end
          if (out_vld_o) begin
            stall_cnt_q <= '0;
            if (owner_flit == FLIT_ID_W'(FLIT_TAIL)) begin
              state_q   <= ARB_IDLE;
              rr_ptr_q  <= owner_q;
              pkt_cnt_q <= pkt_cnt_q + CNT_W'(1);
            end
          end else if (stall_cnt_q != STALL_W'(STALL_MAX)) begin
            stall_cnt_q <= stall_cnt_q + STALL_W'(1);
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign locked_o  = (state_q == ARB_LOCKED);
  assign err_o     = err_q;
  assign stall_o   = (stall_cnt_q == STALL_W'(STALL_MAX));
  assign pkt_cnt_o = pkt_cnt_q;

endmodule

// File: tb/tb_wormhole_output_arbiter.sv
// Directed bench for wormhole_output_arbiter: a table of per-cycle vectors
// plus hand-written sequences for reset, round-robin, stall, errors.
module tb_wormhole_output_arbiter;

  localparam logic [1:0] H = 2'b10;
  localparam logic [1:0] B = 2'b00;
  localparam logic [1:0] T = 2'b01;
  localparam logic [1:0] S = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  req;
  logic [9:0]  flit_id;
  logic        out_rdy;
  logic [4:0]  gnt;
  logic [2:0]  sel;
  logic        out_vld;
  logic        locked;
  logic        err;
  logic        stall;
  logic [15:0] pkt_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  wormhole_output_arbiter #(
    .IN_N      (5),
    .FLIT_ID_W (2),
    .STALL_MAX (16),
    .CNT_W     (16)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .req_i     (req),
    .flit_id_i (flit_id),
    .out_rdy_i (out_rdy),
    .gnt_o     (gnt),
    .sel_o     (sel),
    .out_vld_o (out_vld),
    .locked_o  (locked),
    .err_o     (err),
    .stall_o   (stall),
    .pkt_cnt_o (pkt_cnt)
  );

  typedef struct {
    logic [4:0]  req;
    logic [9:0]  flit;
    logic        rdy;
    logic [4:0]  gnt;
    logic [2:0]  sel;
    logic        vld;
    logic        locked;
    logic [15:0] pkt;
  } vec_t;

  vec_t tbl[18];

  function automatic logic [9:0] mk(input logic [1:0] f4, input logic [1:0] f3,
                                    input logic [1:0] f2, input logic [1:0] f1,
                                    input logic [1:0] f0);
    return {f4, f3, f2, f1, f0};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    req     = '0;
    flit_id = '0;
    out_rdy = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // {gnt, sel, vld, locked, err, stall, pkt}
  function automatic logic [63:0] pack(input logic [4:0] g, input logic [2:0] s,
                                       input logic v, input logic l, input logic e,
                                       input logic st, input logic [15:0] p);
    return 64'({g, s, v, l, e, st, p});
  endfunction

  initial begin
    int exp_rr[5];

    // Rows: req, flits (in4..in0), rdy | gnt, sel, vld, locked, pkt (err/stall 0).
    tbl[0]  = '{5'b00100, mk(B, B, S, B, B), 1'b1, 5'b00100, 3'd2, 1'b1, 1'b0, 16'd0};
    tbl[1]  = '{5'b00000, mk(B, B, B, B, B), 1'b1, 5'b00000, 3'd0, 1'b0, 1'b0, 16'd1};
    tbl[2]  = '{5'b00001, mk(B, B, B, B, S), 1'b1, 5'b00001, 3'd0, 1'b1, 1'b0, 16'd1};
    tbl[3]  = '{5'b01010, mk(B, H, B, H, B), 1'b1, 5'b00010, 3'd1, 1'b1, 1'b0, 16'd2};
    tbl[4]  = '{5'b01010, mk(B, H, B, B, B), 1'b1, 5'b00010, 3'd1, 1'b1, 1'b1, 16'd2};
    tbl[5]  = '{5'b01010, mk(B, H, B, B, B), 1'b1, 5'b00010, 3'd1, 1'b1, 1'b1, 16'd2};
    tbl[6]  = '{5'b01010, mk(B, H, B, T, B), 1'b1, 5'b00010, 3'd1, 1'b1, 1'b1, 16'd2};
    tbl[7]  = '{5'b01000, mk(B, H, B, B, B), 1'b1, 5'b01000, 3'd3, 1'b1, 1'b0, 16'd3};
    tbl[8]  = '{5'b01000, mk(B, T, B, B, B), 1'b1, 5'b01000, 3'd3, 1'b1, 1'b1, 16'd3};
    tbl[9]  = '{5'b10101, mk(S, B, S, B, S), 1'b1, 5'b10000, 3'd4, 1'b1, 1'b0, 16'd4};
    tbl[10] = '{5'b10101, mk(S, B, S, B, S), 1'b1, 5'b00001, 3'd0, 1'b1, 1'b0, 16'd5};
    tbl[11] = '{5'b10101, mk(S, B, S, B, S), 1'b1, 5'b00100, 3'd2, 1'b1, 1'b0, 16'd6};
    tbl[12] = '{5'b10101, mk(S, B, S, B, S), 1'b0, 5'b00000, 3'd0, 1'b0, 1'b0, 16'd7};
    tbl[13] = '{5'b00000, mk(B, B, B, B, B), 1'b1, 5'b00000, 3'd0, 1'b0, 1'b0, 16'd7};
    tbl[14] = '{5'b00010, mk(B, B, B, H, B), 1'b1, 5'b00010, 3'd1, 1'b1, 1'b0, 16'd7};
    tbl[15] = '{5'b00100, mk(B, B, S, B, B), 1'b1, 5'b00000, 3'd1, 1'b0, 1'b1, 16'd7};
    tbl[16] = '{5'b00110, mk(B, B, S, T, B), 1'b1, 5'b00010, 3'd1, 1'b1, 1'b1, 16'd7};
    tbl[17] = '{5'b00100, mk(B, B, S, B, B), 1'b1, 5'b00100, 3'd2, 1'b1, 1'b0, 16'd8};

    // Outputs must be quiet while reset is held, even with a valid request.
    rst     = 1'b1;
    req     = 5'b00001;
    flit_id = mk(B, B, B, B, S);
    out_rdy = 1'b1;
    #2;
    chk("reset_hold", pack(gnt, sel, out_vld, locked, err, stall, pkt_cnt),
        pack(5'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0));
    tick();
    rst = 1'b0;

    // Table: one row per cycle, outputs sampled on the falling edge.
    for (int i = 0; i < 18; i++) begin
      req     = tbl[i].req;
      flit_id = tbl[i].flit;
      out_rdy = tbl[i].rdy;
      @(negedge clk);
      chk($sformatf("vec%0d", i), pack(gnt, sel, out_vld, locked, err, stall, pkt_cnt),
          pack(tbl[i].gnt, tbl[i].sel, tbl[i].vld, tbl[i].locked, 1'b0, 1'b0, tbl[i].pkt));
      tick();
    end

    // Round-robin from reset: inputs 0, 2, 4 sending SINGLE continuously.
    do_reset();
    exp_rr = '{0, 2, 4, 0, 2};
    req     = 5'b10101;
    flit_id = mk(S, B, S, B, S);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("rr%0d", k), 64'({gnt, sel, out_vld}),
          64'({5'(5'b1 << exp_rr[k]), 3'(exp_rr[k]), 1'b1}));
      tick();
    end

    // Backpressure and stall on a locked packet from input 0.
    do_reset();
    req     = 5'b00001;
    flit_id = mk(B, B, B, B, H);
    @(negedge clk);
    chk("stall_head", 64'({gnt, out_vld}), 64'({5'b00001, 1'b1}));
    tick();
    flit_id = mk(B, B, B, B, B);
    out_rdy = 1'b0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      chk($sformatf("stall_c%0d", j), 64'({gnt, out_vld, locked, stall}),
          64'({5'b0, 1'b0, 1'b1, 1'(j >= 16)}));
      tick();
    end
    out_rdy = 1'b1;
    @(negedge clk);
    chk("stall_resume", 64'({gnt, out_vld}), 64'({5'b00001, 1'b1}));
    tick();
    req = 5'b0;
    @(negedge clk);
    chk("stall_clear", 64'({stall, locked}), 64'({1'b0, 1'b1}));
    tick();
    req     = 5'b00001;
    flit_id = mk(B, B, B, B, T);
    tick();
    req = 5'b0;
    @(negedge clk);
    chk("stall_done", 64'({locked, pkt_cnt}), 64'({1'b0, 16'd1}));

    // Protocol errors: BODY while idle, then HEAD from the owner while locked.
    do_reset();
    req     = 5'b01000;
    flit_id = mk(B, B, B, B, B);
    @(negedge clk);
    chk("err_idle_nogrant", 64'({gnt, out_vld, err}), 64'({5'b0, 1'b0, 1'b0}));
    tick();
    req = 5'b0;
    @(negedge clk);
    chk("err_idle_set", 64'({err, locked}), 64'({1'b1, 1'b0}));
    tick();
    req     = 5'b00001;
    flit_id = mk(B, B, B, B, H);
    tick();
    @(negedge clk);
    chk("err_lock_fwd", 64'({gnt, out_vld, locked}), 64'({5'b00001, 1'b1, 1'b1}));
    tick();
    flit_id = mk(B, B, B, B, B);
    @(negedge clk);
    chk("err_lock_kept", 64'({err, locked, gnt}), 64'({1'b1, 1'b1, 5'b00001}));

    // Asynchronous reset in the middle of the BODY flit above.
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset", pack(gnt, sel, out_vld, locked, err, stall, pkt_cnt),
        pack(5'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0));
    tick();
    rst     = 1'b0;
    req     = 5'b10001;
    flit_id = mk(S, B, B, B, S);
    @(negedge clk);
    chk("post_reset_prio", pack(gnt, sel, out_vld, locked, err, stall, pkt_cnt),
        pack(5'b00001, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0));
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wormhole_output_arbiter.md
Name: wormhole_output_arbiter

Overview:
- Per-output-channel packet arbiter for the 2D-mesh wormhole node; one instance per output port.
- Grants the output to one requesting input channel at HEAD time using round-robin priority.
- Holds that grant (wormhole lock) until the packet's TAIL flit has transferred.
- Drives the crossbar select, the output valid and the per-input grant; also reports protocol errors, stalls and a packet count.

Parameters:
- IN_N, 5, number of input channels competing for this output.
- FLIT_ID_W, 2, width of the flit type field.
- STALL_MAX, 16, consecutive locked cycles without a transfer before stall_o asserts.
- CNT_W, 16, width of the completed-packet counter.

Ports:
- clk_i  input  1  clock; the block has one clock.
- rst_i  input  1  reset, asynchronous, active-high.
- req_i  input  IN_N  bit i = input i holds a valid flit routed to this output.
- flit_id_i  input  IN_N*FLIT_ID_W  flit type of the head-of-FIFO flit per input, input i at bits [i*FLIT_ID_W +: FLIT_ID_W].
- out_rdy_i  input  1  downstream FIFO not full.
- gnt_o  output  IN_N  one-hot; input i's flit is consumed this cycle.
- sel_o  output  $clog2(IN_N)  crossbar select (input index).
- out_vld_o  output  1  flit written downstream this cycle.
- locked_o  output  1  a packet currently owns the output.
- err_o  output  1  sticky protocol-error flag.
- stall_o  output  1  locked owner idle for at least STALL_MAX cycles.
- pkt_cnt_o  output  CNT_W  completed packets, wraps modulo 2^CNT_W.

Behaviour:
- Flit types: HEAD=2'b10, BODY=2'b00, TAIL=2'b01, SINGLE=2'b11 (head and tail in one flit).
- Reset (async, rst_i=1):
  - state=IDLE, rr_ptr=IN_N-1, owner=0, stall counter=0, err_o=0, pkt_cnt_o=0.
  - gnt_o=0, out_vld_o=0, sel_o=0, locked_o=0, stall_o=0 while reset is held.
  - Reset mid-packet drops the lock immediately; no partial-packet recovery.
- Transfer: xfer = out_vld_o, requiring out_rdy_i=1.
  - gnt_o, sel_o and out_vld_o are combinational from the current state and inputs, giving zero-cycle grant latency.
- IDLE state:
  - Eligible inputs: req_i[i]=1 and flit_id_i[i] is HEAD or SINGLE.
  - Winner: the first eligible index searching rr_ptr+1, rr_ptr+2, … modulo IN_N.
  - If an eligible input exists and out_rdy_i=1: gnt_o=onehot(winner), sel_o=winner, out_vld_o=1.
    - HEAD → next state LOCKED, owner=winner.
    - SINGLE → stay IDLE, rr_ptr=winner, pkt_cnt++.
  - If out_rdy_i=0: no grant and no state change; the winner is recomputed next cycle.
  - A requester presenting BODY/TAIL while IDLE is ignored and sets err_o.
- LOCKED state (locked_o=1):
  - sel_o=owner always.
  - If req_i[owner] & out_rdy_i: gnt_o=onehot(owner), out_vld_o=1.
  - Requests from other inputs are ignored (no grant, no error).
  - On transfer of a TAIL flit: next state IDLE, rr_ptr=owner, pkt_cnt++.
  - Owner presenting HEAD/SINGLE while LOCKED: err_o is set, the flit is still forwarded, and the lock is kept.
- Stall counter:
  - Counts in LOCKED on cycles with no transfer; cleared on any transfer and on leaving LOCKED.
  - Saturates at STALL_MAX.
  - stall_o = (counter == STALL_MAX).
- err_o is cleared only by reset.
- Fairness: no input waits more than IN_N-1 packets once eligible.

Decomposition:
- Package wormhole_pkg:
  - Flit type constants FLIT_HEAD, FLIT_BODY, FLIT_TAIL, FLIT_SINGLE.
  - State encodings ARB_IDLE, ARB_LOCKED.
- Sub-module rr_priority_picker: combinational.
  - Inputs: eligible vector, rr_ptr.
  - Outputs: winner index, any_vld.
  - Parameter IN_N; reused by future VC allocators.

Test Plan:
- Single-flit packet: reset; req_i=5'b00100, flit[2]=SINGLE, out_rdy_i=1.
  - Same cycle gnt_o=00100, sel_o=2, out_vld_o=1.
  - Next cycle state IDLE, pkt_cnt_o=1.
- Wormhole lock: input 1 sends HEAD, BODY, BODY, TAIL while input 3 requests HEAD throughout.
  - gnt_o=00010 for 4 consecutive cycles.
  - Input 3 granted on the 5th cycle; pkt_cnt_o=2.
- Round-robin order: inputs 0, 2, 4 request SINGLE continuously from reset.
  - Grant order 0, 2, 4, 0, 2.
- Backpressure and stall: locked on input 0, out_rdy_i=0 for 20 cycles.
  - out_vld_o=0 and gnt_o=0 throughout.
  - stall_o asserts at cycle 16 and deasserts on the first transfer after out_rdy_i=1.
- Protocol errors:
  - IDLE with req_i[3]=1, flit=BODY → no grant, err_o=1.
  - Owner sending HEAD while LOCKED → flit forwarded, err_o stays 1, locked_o=1.
- Async reset mid-packet: assert rst_i during a BODY flit.
  - Outputs 0 immediately, without waiting for a clock edge.
  - After release, locked_o=0, pkt_cnt_o=0, and input 0 has first priority.
